periph_sqrt_fx: RTL
===================

Name: periph_sqrt_fx

Overview:
- Memory-mapped fixed-point square-root peripheral for the FemtoRV32 I/O bus; generalised successor of the 8-bit sqrt peripheral.
- Operand width and result fractional bits are parameterised. Adds busy/done/overrun status, write-1-to-clear, an optional interrupt and a registered read path.
- Iterative digit-by-digit (restoring, bit-pair) core produces one result bit per clock.

Parameters:
- DATA_W, 16, operand width in bits; must be even, 2..30.
- FRAC_W, 4, fractional bits in the result; result format is Q(DATA_W/2).FRAC_W.
- RES_W, DATA_W/2+FRAC_W (derived, localparam), result width and iteration count; must be ≤32.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  peripheral select from the address decoder
- addr  in  5  byte offset within the peripheral; addr[4:2] selects the register
- rd  in  1  read strobe (qualified by cs)
- wr  in  1  write strobe (qualified by cs)
- d_in  in  32  write data
- d_out  out  32  registered read data
- irq  out  1  level interrupt, = done & irq_en

Behaviour:
- Clock and reset: clock clk; reset is asynchronous, active-high.
- Register map (addr[4:2]):
  - 0 OPERAND: R/W. d_in[DATA_W-1:0]; upper bits ignored.
  - 1 RESULT: RO. Zero-extended RES_W bits.
  - 2 STATUS: bit0 busy RO; bit1 done W1C; bit2 overrun W1C.
  - 3 CTRL: bit0 irq_en RW.
  - 4..7 read 0, writes ignored.
- Reset values: d_out=0, irq=0, operand=0, result=0, busy=0, done=0, overrun=0, irq_en=0, FSM=IDLE, iteration counter=0.
- Reset mid-operation aborts the computation immediately and forces all of the above reset values.
- Read path: on the edge where cs&rd, d_out loads the selected register and is valid the following cycle. Otherwise d_out holds its value.
- Read side effects: reads have none (no clear-on-read).
- Start: cs&wr to OPERAND while busy=0 latches the operand, clears done, and sets busy. The FSM goes IDLE→CALC on that edge.
- Overrun: cs&wr to OPERAND while busy=1 is ignored for the operand and the computation, and sets overrun.
- FSM states:
  - IDLE: wait for start.
  - CALC: RES_W cycles; each cycle resolves one result bit, MSB first. Radicand is the operand << (2·FRAC_W); remainder width RES_W+2.
  - DONE: one cycle. Writes RESULT, busy←0, done←1, then returns to IDLE.
- Latency: start write at edge N. Busy reads 1 from N+1. RESULT and done update at edge N+RES_W+1, which is 13 cycles for the defaults.
- Arithmetic: result = floor(sqrt(operand)·2^FRAC_W), exact (no rounding). Operand 0 gives 0.
- RESULT holds the last completed value until the next completion. It is not cleared on start.
- W1C: writing 1 clears done/overrun; writing 0 leaves them unchanged.
- Same-cycle set and W1C clear of the same bit: set wins.
- Write to STATUS bit0 has no effect.
- irq is combinational from registered done and irq_en, so it is glitch-free. It deasserts the cycle after done is cleared or irq_en is cleared.
- Simultaneous rd and wr to the same register: the read returns the pre-write value.
- No back-to-back pipelining: one operation in flight.

Decomposition:
- Shared package/header:
  - register offsets (REG_OPERAND=0, REG_RESULT=1, REG_STATUS=2, REG_CTRL=3)
  - STATUS bit indices
  - FSM state encoding (IDLE, CALC, DONE)
- Sub-module sqrt_iter_core (params DATA_W, FRAC_W):
  - inputs: start, operand
  - outputs: busy, valid (1-cycle pulse), root[RES_W-1:0]
  - contains the FSM and the remainder/root/counter datapath
- periph_sqrt_fx: bus decode, registers, status/irq logic.

Test Plan:
- Defaults. Write OPERAND=144 → busy=1 next cycle; after 13 cycles done=1, RESULT=0x0C0 (12.0). STATUS read returns 0x2.
- OPERAND=2 → RESULT=0x016 (22 = floor(1.41421·16)). OPERAND=0 → RESULT=0. OPERAND=0xFFFF → RESULT=0xFFF (4095).
- Start 144, then write OPERAND=81 at cycle 5 → overrun=1; RESULT still 0x0C0, produced at the original cycle. Write STATUS=0x6 → done=0, overrun=0.
- CTRL=1, start 100 → irq rises with done (RESULT=0x0A0). Write STATUS=0x2 → irq=0 next cycle. Repeat with CTRL=0 → irq stays 0.
- Assert reset at cycle 6 of a computation → all status, RESULT, d_out and irq are 0. A fresh start of 49 then yields RESULT=0x070 with normal latency.
- Align W1C of done with the completion edge → done=1 (set wins). Read addr 0x14 → d_out=0. Rerun with DATA_W=8, FRAC_W=0: OPERAND=200 → RESULT=14, latency 5 cycles.

Source files
------------

// File: rtl/periph_sqrt_fx_pkg.sv
// periph_sqrt_fx_pkg: register offsets, status bit indices and FSM encoding
package periph_sqrt_fx_pkg;
   localparam logic [2:0] REG_OPERAND = 3'd0;
   localparam logic [2:0] REG_RESULT  = 3'd1;
   localparam logic [2:0] REG_STATUS  = 3'd2;
   localparam logic [2:0] REG_CTRL    = 3'd3;
   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_OVR  = 2;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
endpackage

// File: rtl/periph_sqrt_fx_core.sv
// sqrt_iter_core: restoring bit-pair square root, one result bit per clock, MSB first
module sqrt_iter_core
   import periph_sqrt_fx_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 4,
   localparam int RES_W = DATA_W/2 + FRAC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [DATA_W-1:0] operand_i,
   output logic              busy_o,
   output logic              valid_o,
   output logic [RES_W-1:0]  root_o
);
   state_t             state_q;
   logic               busy_q, valid_q, ge;
   logic [2*RES_W-1:0] rad_q;
   logic [RES_W+1:0]   rem_q, rem_t, trial, rem_d;
   logic [RES_W-1:0]   root_q, root_d;
   logic [5:0]         cnt_q;
   // remainder gets the next radicand bit pair; compare against 4*root+1
   assign rem_t  = (rem_q << 2) | (RES_W+2)'(rad_q[2*RES_W-1 -: 2]);
   assign trial  = {root_q, 2'b01};
   assign ge     = rem_t >= trial;
   assign rem_d  = ge ? rem_t - trial : rem_t;
   assign root_d = (root_q << 1) | RES_W'(ge);
   assign busy_o  = busy_q;
   assign valid_o = valid_q;
   assign root_o  = root_q;
   // IDLE -> CALC (RES_W iterations) -> DONE (one cycle, valid pulse) -> IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         rad_q   <= '0;
         rem_q   <= '0;
         root_q  <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (start_i) begin
               rad_q   <= (2*RES_W)'(operand_i) << (2*FRAC_W);
               rem_q   <= '0;
               root_q  <= '0;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               state_q <= S_CALC;
            end
            S_CALC: begin
               rad_q  <= rad_q << 2;
               rem_q  <= rem_d;
               root_q <= root_d;
               cnt_q  <= cnt_q + 6'd1;
               if (cnt_q == 6'(RES_W-1)) begin
                  state_q <= S_DONE;
                  valid_q <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/periph_sqrt_fx.sv
// periph_sqrt_fx: memory-mapped fixed-point square-root peripheral with status and irq
module periph_sqrt_fx
   import periph_sqrt_fx_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 4,
   localparam int RES_W = DATA_W/2 + FRAC_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_i,
   input  logic [4:0]  addr_i,
   input  logic        rd_i,
   input  logic        wr_i,
   input  logic [31:0] d_in_i,
   output logic [31:0] d_out_o,
   output logic        irq_o
);
   logic [2:0]        sel;
   logic              wr_op, wr_st, wr_ctl, start, busy, valid;
   logic              done_q, ovr_q, irq_en_q;
   logic [RES_W-1:0]  root, result_q;
   logic [DATA_W-1:0] operand_q;
   logic [31:0]       status, rdata, d_out_q;
   logic              unused_bits;
   assign sel         = addr_i[4:2];
   assign wr_op       = cs_i & wr_i & (sel == REG_OPERAND);
   assign wr_st       = cs_i & wr_i & (sel == REG_STATUS);
   assign wr_ctl      = cs_i & wr_i & (sel == REG_CTRL);
   assign start       = wr_op & ~busy;
   assign irq_o       = done_q & irq_en_q;
   assign d_out_o     = d_out_q;
   assign unused_bits = ^{addr_i[1:0], d_in_i[31:DATA_W]};
   sqrt_iter_core #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_core (
      .clk       (clk),
      .reset     (reset),
      .start_i   (start),
      .operand_i (d_in_i[DATA_W-1:0]),
      .busy_o    (busy),
      .valid_o   (valid),
      .root_o    (root)
   );
   // read mux over the register map; unmapped offsets read zero
   always_comb begin
      status         = '0;
      status[ST_BUSY] = busy;
      status[ST_DONE] = done_q;
      status[ST_OVR]  = ovr_q;
      rdata = (sel == REG_OPERAND) ? 32'(operand_q) :
              (sel == REG_RESULT)  ? 32'(result_q)  :
              (sel == REG_STATUS)  ? status         :
              (sel == REG_CTRL)    ? {31'b0, irq_en_q} : 32'b0;
   end
   // register file; completion sets done even when a W1C lands on the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         operand_q <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
         irq_en_q  <= 1'b0;
         d_out_q   <= '0;
      end else begin
         if (start) operand_q <= d_in_i[DATA_W-1:0];
         if (valid) result_q <= root;
         done_q <= valid | (done_q & ~start & ~(wr_st & d_in_i[ST_DONE]));
         ovr_q  <= (wr_op & busy) | (ovr_q & ~(wr_st & d_in_i[ST_OVR]));
         if (wr_ctl) irq_en_q <= d_in_i[0];
         if (cs_i & rd_i) d_out_q <= rdata;
      end
   end
endmodule
